// File: rtl/ctrl_seq_counters.sv
// Tap/stage/vector sequencer that runs beside the upsampler controller FSM.
// Define CTRL_SEQ_CHECK_EN to build the sticky illegal-transition monitor (o_seq_err).
module ctrl_seq_counters #(
  parameter int TAPS    = 16,
  parameter int STAGES  = 4,
  parameter int VECTORS = 2,
  parameter int TW      = $clog2(TAPS),
  parameter int SW      = (STAGES > 1) ? $clog2(STAGES) : 1,
  parameter int VW      = (VECTORS > 1) ? $clog2(VECTORS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [2:0]       i_state,
  output logic             o_vector_pass,
  output logic             o_last_stage,
  output logic             o_last_vector,
  output logic [TW-1:0]    o_tap_idx,
  output logic [SW-1:0]    o_stage_idx,
  output logic [VW-1:0]    o_vector_idx,
  output logic [VW+TW-1:0] o_coef_addr,
  output logic             o_mac_init,
  output logic             o_mac_acc,
  output logic             o_out_strobe,
  output logic             o_in_strobe,
  output logic             o_seq_err
);

  localparam logic [2:0] S1 = 3'b000;
  localparam logic [2:0] S2 = 3'b001;
  localparam logic [2:0] S3 = 3'b010;
  localparam logic [2:0] S4 = 3'b011;
  localparam logic [2:0] S5 = 3'b100;
  localparam logic [2:0] S6 = 3'b101;
  localparam logic [2:0] S7 = 3'b110;
  localparam logic [2:0] S8 = 3'b111;

  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
  localparam logic [VW-1:0] VEC_LAST   = VW'(VECTORS - 1);

  logic [TW-1:0] r_tap;
  logic [SW-1:0] r_stage;
  logic [VW-1:0] r_vec;

  logic w_in_s3;
  logic w_tap_last;

  assign w_in_s3    = (i_state == S3);
  assign w_tap_last = (r_tap == TAP_LAST);

  // Tap counter saturates at TAPS-1 so a late FSM exit cannot wrap the ROM address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tap <= '0;
    end else if (i_en) begin
      if (i_state == S2) begin
        r_tap <= '0;
      end else if (w_in_s3 && !w_tap_last) begin
        r_tap <= r_tap + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage <= '0;
      r_vec   <= '0;
    end else if (i_en && (i_state == S8)) begin
      if (r_stage != STAGE_LAST) begin
        r_stage <= r_stage + 1'b1;
      end else begin
        r_stage <= '0;
        r_vec   <= (r_vec == VEC_LAST) ? '0 : r_vec + 1'b1;
      end
    end
  end

  assign o_vector_pass = w_in_s3 && w_tap_last;
  assign o_last_stage  = (r_stage == STAGE_LAST);
  assign o_last_vector = (r_vec == VEC_LAST);
  assign o_tap_idx     = r_tap;
  assign o_stage_idx   = r_stage;
  assign o_vector_idx  = r_vec;
  assign o_coef_addr   = {r_vec, r_tap};

  assign o_mac_init   = i_en && (i_state == S2);
  assign o_mac_acc    = i_en && w_in_s3;
  assign o_out_strobe = i_en && (i_state == S6);
  assign o_in_strobe  = i_en && (i_state == S7);

`ifdef CTRL_SEQ_CHECK_EN
  logic [2:0] r_prev_state;
  logic       r_prev_vp;
  logic       r_seq_err;
  logic       w_legal;
  logic       w_bad_exit;

  always_comb begin
    w_legal = 1'b0;
    case (r_prev_state)
      S1:      w_legal = (i_state == S2);
      S2:      w_legal = (i_state == S3);
      S3:      w_legal = (i_state == S3) || (i_state == S4);
      S4:      w_legal = (i_state == S5);
      S5:      w_legal = (i_state == S6) || (i_state == S8);
      S6:      w_legal = (i_state == S7) || (i_state == S8);
      S7:      w_legal = (i_state == S8);
      S8:      w_legal = (i_state == S1);
      default: w_legal = 1'b0;
    endcase
    if (i_state == r_prev_state) begin
      w_legal = 1'b1;
    end
  end

  // Leaving S3 is only sound if the last tap was flagged on the previous enabled cycle.
  assign w_bad_exit = (r_prev_state == S3) && !w_in_s3 && !r_prev_vp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_state <= S1;
      r_prev_vp    <= 1'b0;
      r_seq_err    <= 1'b0;
    end else if (i_en) begin
      r_prev_state <= i_state;
      r_prev_vp    <= o_vector_pass;
      if (!w_legal || w_bad_exit) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign o_seq_err = r_seq_err;
`else
  assign o_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq_counters.sv
// Directed, table-driven bench for ctrl_seq_counters (TAPS=16, STAGES=4, VECTORS=2).
module tb_ctrl_seq_counters;

  localparam logic [2:0] S1 = 3'b000;
  localparam logic [2:0] S2 = 3'b001;
  localparam logic [2:0] S3 = 3'b010;
  localparam logic [2:0] S4 = 3'b011;
  localparam logic [2:0] S5 = 3'b100;
  localparam logic [2:0] S6 = 3'b101;
  localparam logic [2:0] S7 = 3'b110;
  localparam logic [2:0] S8 = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] state;
  logic       vector_pass, last_stage, last_vector;
  logic [3:0] tap_idx;
  logic [1:0] stage_idx;
  logic [0:0] vector_idx;
  logic [4:0] coef_addr;
  logic       mac_init, mac_acc, out_strobe, in_strobe, seq_err;

  int checks   = 0;
  int failures = 0;

  ctrl_seq_counters #(
    .TAPS    (16),
    .STAGES  (4),
    .VECTORS (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_state       (state),
    .o_vector_pass (vector_pass),
    .o_last_stage  (last_stage),
    .o_last_vector (last_vector),
    .o_tap_idx     (tap_idx),
    .o_stage_idx   (stage_idx),
    .o_vector_idx  (vector_idx),
    .o_coef_addr   (coef_addr),
    .o_mac_init    (mac_init),
    .o_mac_acc     (mac_acc),
    .o_out_strobe  (out_strobe),
    .o_in_strobe   (in_strobe),
    .o_seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  // Row expectation packs {tap, stage, vec, vp, ls, lv, init, acc, out, in}.
  typedef struct {
    logic        en;
    logic [2:0]  st;
    logic [13:0] exp;
  } row_t;

  row_t tbl[22];

  function automatic row_t mk(logic e, logic [2:0] s, logic [3:0] tap, logic [1:0] stg,
                              logic v, logic [6:0] flags);
    row_t r;
    r.en  = e;
    r.st  = s;
    r.exp = {tap, stg, v, flags};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] s);
    en    = e;
    state = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, S1);
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] exp_stage[8];
  logic       exp_vec[8];
  logic       exp_err;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    state = S1;
    tick();
    tick();
    #2;
    chk("reset_regs", {28'd0, tap_idx, stage_idx, vector_idx}, 32'd0);
    chk("reset_strobes", {27'd0, mac_init, mac_acc, out_strobe, in_strobe, seq_err}, 32'd0);
    tick();
    rst = 1'b0;

    // Strobe walk, one stage roll, enable gating around tap 5.
    tbl[0]  = mk(1, S1, 0, 0, 0, 7'b0000000);
    tbl[1]  = mk(1, S2, 0, 0, 0, 7'b0001000);
    tbl[2]  = mk(1, S3, 0, 0, 0, 7'b0000100);
    tbl[3]  = mk(1, S4, 1, 0, 0, 7'b0000000);
    tbl[4]  = mk(1, S5, 1, 0, 0, 7'b0000000);
    tbl[5]  = mk(1, S6, 1, 0, 0, 7'b0000010);
    tbl[6]  = mk(1, S7, 1, 0, 0, 7'b0000001);
    tbl[7]  = mk(1, S8, 1, 0, 0, 7'b0000000);
    tbl[8]  = mk(1, S1, 1, 1, 0, 7'b0000000);
    tbl[9]  = mk(1, S2, 1, 1, 0, 7'b0001000);
    tbl[10] = mk(1, S3, 0, 1, 0, 7'b0000100);
    tbl[11] = mk(1, S3, 1, 1, 0, 7'b0000100);
    tbl[12] = mk(1, S3, 2, 1, 0, 7'b0000100);
    tbl[13] = mk(1, S3, 3, 1, 0, 7'b0000100);
    tbl[14] = mk(1, S3, 4, 1, 0, 7'b0000100);
    tbl[15] = mk(0, S3, 5, 1, 0, 7'b0000000);
    tbl[16] = mk(0, S3, 5, 1, 0, 7'b0000000);
    tbl[17] = mk(0, S3, 5, 1, 0, 7'b0000000);
    tbl[18] = mk(1, S3, 5, 1, 0, 7'b0000100);
    tbl[19] = mk(1, S4, 6, 1, 0, 7'b0000000);
    tbl[20] = mk(0, S2, 6, 1, 0, 7'b0000000);
    tbl[21] = mk(1, S4, 6, 1, 0, 7'b0000000);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].en, tbl[i].st);
      #2;
      chk($sformatf("row%0d", i),
          {18'd0, tap_idx, stage_idx, vector_idx, vector_pass, last_stage, last_vector,
           mac_init, mac_acc, out_strobe, in_strobe},
          {18'd0, tbl[i].exp});
      tick();
    end

    // Full convolution: 16 S3 cycles, vector_pass only on the last, then saturation.
    drive(1, S2);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, S3);
      #2;
      chk($sformatf("conv_tap%0d", i), {28'd0, tap_idx}, i);
      chk($sformatf("conv_vp%0d", i), {31'd0, vector_pass}, {31'd0, (i == 15)});
      if (i == 15) chk("conv_coef", {27'd0, coef_addr}, 32'h0F);
      tick();
    end
    drive(1, S3);
    #2;
    chk("tap_saturate", {27'd0, vector_pass, tap_idx}, {27'd0, 1'b1, 4'd15});
    tick();
    drive(1, S4);
    #2;
    chk("after_s3", {27'd0, vector_pass, tap_idx}, {27'd0, 1'b0, 4'd15});
    tick();

    // Stage/vector roll over 8 S8 visits.
    exp_stage = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_vec   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, S8);
      tick();
      #1;
      chk($sformatf("roll%0d", i), {28'd0, stage_idx, vector_idx, last_stage, last_vector},
          {27'd0, exp_stage[i], exp_vec[i], (exp_stage[i] == 2'd3), exp_vec[i]});
      chk($sformatf("roll_coef%0d", i), {27'd0, coef_addr}, {27'd0, exp_vec[i], 4'd0});
    end

    // Asynchronous reset mid-S3 with tap_idx=7 and a nonzero stage.
    do_reset();
    drive(1, S8);
    tick();
    drive(1, S2);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, S3);
      tick();
    end
    chk("pre_rst_tap", {26'd0, tap_idx, stage_idx}, {26'd0, 4'd7, 2'd1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {25'd0, tap_idx, stage_idx, vector_idx}, 32'd0);
    chk("async_rst_err", {31'd0, seq_err}, 32'd0);
    tick();
    drive(0, S1);
    tick();
    rst = 1'b0;

    // Illegal S3->S5 jump.
`ifdef CTRL_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive(1, S1);
    tick();
    drive(1, S2);
    tick();
    drive(1, S3);
    tick();
    drive(1, S5);
    #2;
    chk("err_before", {31'd0, seq_err}, 32'd0);
    tick();
    chk("err_after", {31'd0, seq_err}, {31'd0, exp_err});
    drive(1, S1);
    tick();
    tick();
    chk("err_sticky", {31'd0, seq_err}, {31'd0, exp_err});
    do_reset();
    chk("err_cleared", {31'd0, seq_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
